subtractor_16bit_serial: RTL and testbench
==========================================

// Module: subtractor_16bit_serial
// PURPOSE
//  Multi-cycle 16-bit unsigned subtractor; the inverse of the 16-bit adder datapath.
//  Computes y = a - b - Bin and borrow-out Bo, one SLICE-bit nibble per cycle, LSB first.
//  Each nibble's borrow is registered into the next nibble.
//  Valid/ready on input and output; sits beside adder_16bit in the arithmetic unit.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of SLICE
//  SLICE  4   bits processed per cycle; NSLICE = WIDTH/SLICE = 4 cycles of compute
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands a, b, Bin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend, unsigned
//  b          in   WIDTH  subtrahend, unsigned
//  Bin        in   1      borrow-in
//  out_valid  out  1      y and Bo valid
//  out_ready  in   1      consumer accepts result
//  y          out  WIDTH  difference, mod 2^WIDTH
//  Bo         out  1      borrow-out; 1 iff a < b + Bin (unsigned)
// BEHAVIOUR
//  Reset (rst=1 at clk edge)
//   - state=IDLE; in_ready=1; out_valid=0; y=0; Bo=0.
//   - Internal operand, borrow and slice-counter registers are cleared.
//  FSM states: IDLE, CALC, DONE
//   - IDLE: in_ready=1. On in_valid&in_ready:
//       latch a, b; borrow register <= Bin; slice counter <= 0; go to CALC.
//   - CALC: in_ready=0. Each cycle, slice k (bits k*SLICE +: SLICE) does
//       {borrow', y[k]} = a[k] - b[k] - borrow.
//     Result bits and the borrow are registered; counter increments.
//     After slice NSLICE-1, Bo <= final borrow; go to DONE.
//   - DONE: out_valid=1; y and Bo held stable. On out_ready: go to IDLE.
//     out_valid falls on the next cycle.
//  Latency
//   - Accept at edge T; out_valid rises at edge T+NSLICE (T+4 by default).
//   - Minimum issue interval is NSLICE+2 cycles (no accept in DONE or CALC).
//  Width and arithmetic rule
//   - Equivalent to the 17-bit diff = {1'b0,a} - {1'b0,b} - Bin.
//   - y = diff[15:0]; Bo = diff[16].
//  Boundary conditions
//   - Operand inputs are sampled only at accept. Changes during CALC/DONE are ignored.
//   - in_valid while in_ready=0: no effect; the source must hold until accepted.
//   - out_ready low: DONE holds indefinitely with y/Bo constant.
//   - out_ready high before out_valid: no effect.
//   - Bin=1 with b=FFFF: the borrow propagates correctly across all slices.
//   - y is not cleared between operations. It is only meaningful while out_valid=1.
//   - rst in CALC or DONE aborts the operation, applies reset values next cycle,
//     and never emits a partial result.
//   - rst and in_valid in the same cycle: rst wins, nothing is accepted.
// TESTING
//  1. a=0000, b=0001, Bin=0 -> y=FFFF, Bo=1; out_valid rises exactly 4 cycles after accept.
//  2. a=1234, b=0234, Bin=0 -> y=1000, Bo=0.
//     a=8000, b=8000, Bin=1 -> y=FFFF, Bo=1.
//  3. a=0000, b=FFFF, Bin=1 -> y=0000, Bo=1 (full borrow chain through all slices).
//  4. Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, y, Bo stay stable.
//     Operands changed during CALC do not alter the result. in_ready stays 0 until DONE exits.
//  5. Assert rst during the 2nd CALC cycle -> next cycle IDLE, in_ready=1, out_valid=0, y=0, Bo=0.
//     The next operation (a=0005, b=0003) -> y=0002, Bo=0.
//  6. 100 random {a, b, Bin} with random out_ready stalls -> every result matches the
//     17-bit reference model; error count 0.

Source files
------------

// File: rtl/subtractor_16bit_serial_if.sv
// Operand/result handshake bundle for the serial subtractor.
interface subtractor_16bit_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             Bo;

    // Source of operands and sink of results.
    modport master (
        output in_valid, a, b, Bin, out_ready,
        input  in_ready, out_valid, y, Bo
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, Bin, out_ready,
        output in_ready, out_valid, y, Bo
    );
endinterface

// File: rtl/subtractor_16bit_serial.sv
// Multi-cycle unsigned subtractor: y = a - b - Bin, one SLICE-bit slice per
// cycle, LSB first, with the slice borrow registered into the next slice.
module subtractor_16bit_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    subtractor_16bit_serial_if.slave    bus
);
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   y_q;
    logic               borrow_q;
    logic               bo_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SLICE:0]     slice_diff_c;

    // Current slice difference; the extra MSB is the borrow into the next slice.
    always_comb begin
        slice_diff_c = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]}
                     - (SLICE+1)'(borrow_q);
    end

    // Control FSM and datapath; operands shift down so slice 0 is always the LSBs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            y_q         <= '0;
            borrow_q    <= 1'b0;
            bo_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        borrow_q   <= bus.Bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    a_q      <= a_q >> SLICE;
                    b_q      <= b_q >> SLICE;
                    y_q      <= {slice_diff_c[SLICE-1:0], y_q[WIDTH-1:SLICE]};
                    borrow_q <= slice_diff_c[SLICE];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NSLICE - 1)) begin
                        bo_q        <= slice_diff_c[SLICE];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.Bo        = bo_q;
endmodule

// File: tb/tb_subtractor_16bit_serial.sv
// Scoreboard bench for the serial subtractor: stimulus pushes expected
// {Bo, y}; a monitor pops and compares on every output handshake.
module tb_subtractor_16bit_serial;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [16:0] sb_q[$];

    subtractor_16bit_serial_if #(.WIDTH(16)) bus ();

    subtractor_16bit_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: a result is consumed when out_valid and out_ready are both high.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", {bus.Bo, bus.y});
            end else begin
                logic [16:0] exp;
                exp = sb_q.pop_front();
                check("result", 32'({bus.Bo, bus.y}), 32'(exp));
            end
        end
    end

    // One operation: accept, optional early out_ready, stall in DONE, handshake.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                         input logic [16:0] exp, input int stall, input bit early_rdy,
                         input bit chk_lat);
        int guard;
        bit acc;
        int lat;
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.Bin       = bin;
        bus.out_ready = early_rdy;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            acc = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        sb_q.push_back(exp);
        bus.in_valid = 1'b0;
        bus.a        = 16'($urandom);
        bus.b        = 16'($urandom);
        bus.Bin      = 1'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            if (lat == 1) check("in_ready_calc", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        if (chk_lat) check("latency", 32'(lat), 32'd4);
        if (bus.out_valid !== 1'b1) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        if (!early_rdy) begin
            for (int i = 0; i < stall; i++) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_y_bo", 32'({bus.Bo, bus.y}), 32'(exp));
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                @(posedge clk);
                #1;
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("post_valid", 32'(bus.out_valid), 32'd0);
        check("post_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int guard;
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.Bin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y_bo", 32'({bus.Bo, bus.y}), 32'd0);
        rst = 1'b0;

        // Directed vectors, hand-computed.
        do_op(16'h0000, 16'h0001, 1'b0, {1'b1, 16'hFFFF}, 0, 1'b0, 1'b1);
        do_op(16'h1234, 16'h0234, 1'b0, {1'b0, 16'h1000}, 1, 1'b0, 1'b1);
        do_op(16'h8000, 16'h8000, 1'b1, {1'b1, 16'hFFFF}, 0, 1'b1, 1'b1);
        do_op(16'h0000, 16'hFFFF, 1'b1, {1'b1, 16'h0000}, 0, 1'b0, 1'b1);
        do_op(16'hFFFF, 16'h0000, 1'b0, {1'b0, 16'hFFFF}, 2, 1'b0, 1'b1);
        do_op(16'hA5A5, 16'h5A5A, 1'b1, {1'b0, 16'h4B4A}, 5, 1'b0, 1'b1);

        // Abort during the second CALC cycle.
        bus.in_valid = 1'b1;
        bus.a        = 16'h1111;
        bus.b        = 16'h2222;
        bus.Bin      = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("abort_accepted", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_y_bo", 32'({bus.Bo, bus.y}), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_result", 32'(bus.out_valid), 32'd0);
        do_op(16'h0005, 16'h0003, 1'b0, {1'b0, 16'h0002}, 0, 1'b0, 1'b1);

        // rst and in_valid together: nothing accepted.
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.a        = 16'h0009;
        bus.b        = 16'h0001;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_vs_valid_ready", 32'(bus.in_ready), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        check("rst_vs_valid_none", 32'({bus.out_valid, bus.in_ready}), 32'b01);

        // Random operands with random stalls against the 17-bit reference.
        for (int i = 0; i < 100; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rbin;
            logic [16:0] rexp;
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb} - 17'(rbin);
            do_op(ra, rb, rbin, rexp, int'($urandom_range(0, 3)), 1'($urandom), 1'b0);
        end

        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
